io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- 8N1 UART transmitter for the on-board UART, the transmit counterpart of the existing UART receive path.
- CPU-side writes push bytes into a small FIFO.
- The serializer drains the FIFO onto the tx line at a runtime-programmable bit period.
- Sits beside the other io_* peripherals and is driven from the 200 MHz-derived system clock.

Parameters:
- DIV_WIDTH, 16, width of the bit-period divisor input.
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16 entries.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- divisor  in  DIV_WIDTH  bit period minus one, in clk cycles.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe; accepted iff wr_en && !full at the clock edge.
- full  out  1  FIFO holds 2^FIFO_AW entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  FIFO_AW+1  number of FIFO entries.
- busy  out  1  serializer not IDLE (a frame is in progress).
- tx  out  1  serial line, idle high.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (register outputs, valid the cycle after rst is sampled high):
  - tx=1, busy=0, count=0, empty=1, full=0.
  - FSM=IDLE; FIFO pointers=0.
- Reset mid-frame aborts the frame; tx returns high immediately on the next edge. FIFO contents are discarded.
- FIFO:
  - full = (count == 2^FIFO_AW); empty = (count == 0).
  - Pointers wrap modulo 2^FIFO_AW.
  - A write while full is dropped silently, even if a pop occurs in the same cycle; count is unchanged by a dropped write.
  - A simultaneous accepted write and pop leaves count unchanged.
- Bit period P = divisor + 1 cycles. divisor is latched into an internal register when a byte is popped, so mid-frame changes affect the next frame only. divisor=0 gives P=1.
- FSM states:
  - IDLE: tx=1. If !empty, pop head into shift register, latch divisor, go to START.
  - START: tx=0 for P cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for P cycles per bit, LSB first, shifting right. After bit 7 completes, go to STOP.
  - STOP: tx=1 for P cycles. In its last cycle: if !empty, pop, latch divisor and go to START (zero idle gap); else go to IDLE.
- Latency:
  - wr_en in cycle 0 into an empty FIFO with FSM IDLE: count=1/empty=0 in cycle 1.
  - IDLE pops at the end of cycle 1; tx=0 from cycle 2.
- Frame length: exactly 10*P cycles. Back-to-back frames are contiguous (period 10*P).
- Bit-period counter: counts 0..P-1 and reloads on state/bit change. Counter width is DIV_WIDTH; no overflow for divisor = 2^DIV_WIDTH-1.
- busy=1 in START/DATA/STOP and 0 in IDLE. busy stays 1 across back-to-back frames.

Test Plan:
- Single byte: rst, then divisor=3, write 0x55 in cycle 0.
  - Required: tx=0 in cycles 2–5; data bits 1,0,1,0,1,0,1,0, each 4 cycles, in cycles 6–37; tx=1 stop in cycles 38–41.
  - busy=0 from cycle 42; empty=1 from cycle 2.
- Back-to-back: divisor=1, write 0xA5 then 0x3C on consecutive cycles.
  - Required: two frames with no idle gap; second start bit begins exactly 20 cycles after the first; busy stays 1 for 40 cycles.
  - LSB-first sequence: 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Overflow: divisor=100, write 18 bytes 0x00–0x11 on consecutive cycles.
  - Required: first byte pops, count peaks at 16, full=1; bytes 0x11 dropped; the transmitted sequence is 0x00..0x10, then idle.
- Write while full and popping: FIFO full, wr_en coincides with the STOP→START pop.
  - Required: write dropped; count drops 16→15.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF with 5 bytes queued.
  - Required: tx=1, busy=0, count=0, empty=1 on the next cycle; no further frames.
- Divisor change: divisor=2, write 0x01 and 0x02; change divisor to 5 during the first frame.
  - Required: first frame is 30 cycles; second frame is 60 cycles.

Source files
------------

// File: rtl/io_uart_tx_if.sv
// Write-side bundle of the UART transmitter: byte enqueue strobe plus FIFO status.
interface io_uart_tx_if #(
    parameter int FIFO_AW = 4
);
    logic [7:0]       wr_data;
    logic             wr_en;
    logic             full;
    logic             empty;
    logic [FIFO_AW:0] count;

    modport master (output wr_data, wr_en, input full, empty, count);
    modport slave  (input wr_data, wr_en, output full, empty, count);
endinterface

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter: 2^FIFO_AW-entry byte FIFO drained by a serializer whose
// bit period (divisor + 1 clocks) is latched per frame.
module io_uart_tx #(
    parameter int DIV_WIDTH = 16,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] divisor,
    io_uart_tx_if.slave          wr,
    output logic                 busy,
    output logic                 tx
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   count_q;
    logic               full, empty, accept, pop;

    state_t             state, state_d;
    logic [7:0]         shift, shift_d;
    logic [2:0]         bit_idx, bit_idx_d;
    logic [DIV_WIDTH-1:0] cnt, cnt_d, div_q, div_d;
    logic               tx_q, tx_d;
    logic               last;

    // count never exceeds DEPTH, so its MSB alone means full
    assign full   = count_q[FIFO_AW];
    assign empty  = (count_q == '0);
    assign accept = wr.wr_en && !full;

    assign wr.full  = full;
    assign wr.empty = empty;
    assign wr.count = count_q;
    assign busy     = (state != IDLE);
    assign tx       = tx_q;

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= wr.wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            unique case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            div_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            bit_idx <= bit_idx_d;
            cnt     <= cnt_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
        end
    end

    assign last = (cnt == div_q);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_idx_d = bit_idx;
        cnt_d     = cnt;
        div_d     = div_q;
        pop       = 1'b0;

        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rptr];
                    div_d   = divisor;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_d = STOP;
                    else                 bit_idx_d = bit_idx + 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            STOP: begin
                if (last) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit so queued frames have no gap
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rptr];
                        div_d   = divisor;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next state so the line never glitches
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: frame timing, back-to-back, overflow, reset abort
// and per-frame divisor latching, all against hand-derived waveforms.
module tb_io_uart_tx;
    localparam int DIV_WIDTH = 16;
    localparam int FIFO_AW   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 busy;
    logic                 tx;

    io_uart_tx_if #(.FIFO_AW(FIFO_AW)) wr_if ();

    io_uart_tx #(.DIV_WIDTH(DIV_WIDTH), .FIFO_AW(FIFO_AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .divisor (divisor),
        .wr      (wr_if.slave),
        .busy    (busy),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_byte [32];
    int         exp_p    [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Current cycle must be the first start-bit cycle of frame 0
    task automatic check_frames(input int n);
        for (int f = 0; f < n; f++) begin
            int p;
            p = exp_p[f];
            for (int c = 0; c < 10 * p; c++) begin
                int   b;
                logic e;
                b = c / p;
                if (b == 0)      e = 1'b0;
                else if (b == 9) e = 1'b1;
                else             e = exp_byte[f][b-1];
                check($sformatf("tx f%0d c%0d", f, c), {31'd0, tx}, {31'd0, e});
                check($sformatf("busy f%0d c%0d", f, c), {31'd0, busy}, 32'd1);
                step();
            end
        end
        check("busy_after_frames", {31'd0, busy}, 32'd0);
        check("tx_after_frames", {31'd0, tx}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        divisor        = 16'd3;
        wr_if.wr_en    = 1'b0;
        wr_if.wr_data  = 8'h00;
        step();
        check("rst_tx",    {31'd0, tx},          32'd1);
        check("rst_busy",  {31'd0, busy},        32'd0);
        check("rst_count", {27'd0, wr_if.count}, 32'd0);
        check("rst_empty", {31'd0, wr_if.empty}, 32'd1);
        check("rst_full",  {31'd0, wr_if.full},  32'd0);

        // Single byte 0x55, P=4
        rst           = 1'b0;
        wr_if.wr_en   = 1'b1;
        wr_if.wr_data = 8'h55;
        step();
        wr_if.wr_en = 1'b0;
        check("c1_count", {27'd0, wr_if.count}, 32'd1);
        check("c1_empty", {31'd0, wr_if.empty}, 32'd0);
        check("c1_tx",    {31'd0, tx},          32'd1);
        step();
        check("c2_empty", {31'd0, wr_if.empty}, 32'd1);
        exp_byte[0] = 8'h55; exp_p[0] = 4;
        check_frames(1);

        // Back-to-back 0xA5, 0x3C, P=2
        divisor       = 16'd1;
        wr_if.wr_en   = 1'b1;
        wr_if.wr_data = 8'hA5;
        step();
        wr_if.wr_data = 8'h3C;
        step();
        wr_if.wr_en = 1'b0;
        exp_byte[0] = 8'hA5; exp_p[0] = 2;
        exp_byte[1] = 8'h3C; exp_p[1] = 2;
        check_frames(2);

        // Overflow, then a write while full coinciding with the STOP->START pop
        divisor = 16'd100;
        for (int i = 0; i < 17; i++) begin
            exp_byte[i] = i[7:0];
            exp_p[i]    = 101;
        end
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    wr_if.wr_en   = 1'b1;
                    wr_if.wr_data = i[7:0];
                    if (i == 17) begin
                        check("ovf_count_peak", {27'd0, wr_if.count}, 32'd16);
                        check("ovf_full",       {31'd0, wr_if.full},  32'd1);
                    end
                    step();
                end
                wr_if.wr_en = 1'b0;
                check("ovf_count_after_drop", {27'd0, wr_if.count}, 32'd16);
                for (int i = 18; i < 1011; i++) step();
                check("pre_pop_count", {27'd0, wr_if.count}, 32'd16);
                wr_if.wr_en   = 1'b1;
                wr_if.wr_data = 8'hEE;
                step();
                wr_if.wr_en = 1'b0;
                check("full_pop_count", {27'd0, wr_if.count}, 32'd15);
                check("full_pop_full",  {31'd0, wr_if.full},  32'd0);
            end
            begin
                step();
                step();
                check_frames(17);
            end
        join
        check("ovf_end_empty", {31'd0, wr_if.empty}, 32'd1);

        // Reset during DATA bit 3 of 0xFF with 5 bytes queued, P=2
        divisor = 16'd1;
        for (int i = 0; i < 6; i++) begin
            wr_if.wr_en   = 1'b1;
            wr_if.wr_data = (i == 0) ? 8'hFF : 8'h10 + i[7:0];
            step();
        end
        wr_if.wr_en = 1'b0;
        check("abort_queued", {27'd0, wr_if.count}, 32'd5);
        for (int i = 6; i < 10; i++) step();
        check("abort_pre_tx",   {31'd0, tx},   32'd1);
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_tx",    {31'd0, tx},          32'd1);
        check("abort_busy",  {31'd0, busy},        32'd0);
        check("abort_count", {27'd0, wr_if.count}, 32'd0);
        check("abort_empty", {31'd0, wr_if.empty}, 32'd1);
        begin
            int errs;
            errs = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (tx !== 1'b1 || busy !== 1'b0) errs++;
            end
            check("no_frames_after_rst", errs, 32'd0);
        end

        // Divisor change mid-frame: first frame P=3, second P=6
        divisor = 16'd2;
        exp_byte[0] = 8'h01; exp_p[0] = 3;
        exp_byte[1] = 8'h02; exp_p[1] = 6;
        fork
            begin
                wr_if.wr_en   = 1'b1;
                wr_if.wr_data = 8'h01;
                step();
                wr_if.wr_data = 8'h02;
                step();
                wr_if.wr_en = 1'b0;
                step();
                step();
                step();
                divisor = 16'd5;
            end
            begin
                step();
                step();
                check_frames(2);
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
